// File: rtl/sliding_window_buffer_if.sv
// Pixel-in / window-out bundle for sliding_window_buffer.
// Optional macro SOF_RESYNC_EN adds the in_sof start-of-frame marker.
// Signals:
//   in_valid   : pixel present this cycle (no backpressure)
//   in_sof     : (SOF_RESYNC_EN only) pixel is (0,0) of a new frame
//   in_data    : signed pixel, raster order
//   out_valid  : out_window/out_x/out_y valid this cycle
//   out_window : WINDOW_HEIGHT x WINDOW_WIDTH neighbourhood, row-major, top-left at bit 0
//   out_x/out_y: centre coordinate of out_window
//   frame_done : one-cycle pulse with the final window of a frame
// Modports: slave = window buffer, master = pixel source / window consumer.
interface sliding_window_buffer_if #(
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned WINDOW_WIDTH  = 3,
    parameter int unsigned WINDOW_HEIGHT = 3,
    parameter int unsigned IMAGE_WIDTH   = 640,
    parameter int unsigned IMAGE_HEIGHT  = 480
) ();
    localparam int unsigned XW = $clog2(IMAGE_WIDTH);
    localparam int unsigned YW = $clog2(IMAGE_HEIGHT);
    localparam int unsigned OW = DATA_BITS * WINDOW_HEIGHT * WINDOW_WIDTH;

    logic                        in_valid;
`ifdef SOF_RESYNC_EN
    logic                        in_sof;
`endif
    logic signed [DATA_BITS-1:0] in_data;
    logic                        out_valid;
    logic [OW-1:0]               out_window;
    logic [XW-1:0]               out_x;
    logic [YW-1:0]               out_y;
    logic                        frame_done;

`ifdef SOF_RESYNC_EN
    modport slave  (input  in_valid, in_sof, in_data,
                    output out_valid, out_window, out_x, out_y, frame_done);
    modport master (output in_valid, in_sof, in_data,
                    input  out_valid, out_window, out_x, out_y, frame_done);
`else
    modport slave  (input  in_valid, in_data,
                    output out_valid, out_window, out_x, out_y, frame_done);
    modport master (output in_valid, in_data,
                    input  out_valid, out_window, out_x, out_y, frame_done);
`endif
endinterface

// File: rtl/sliding_window_buffer.sv
// Raster-stream to WINDOW_HEIGHT x WINDOW_WIDTH neighbourhood generator feeding
// the keypoint / non-max-suppression stage. Only windows fully inside the image
// are flagged valid; there is no edge padding.
// Optional macro SOF_RESYNC_EN: in_valid && in_sof forces the pixel to (0,0).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : sliding_window_buffer_if.slave (pixel input, window output, frame_done)
module sliding_window_buffer #(
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned WINDOW_WIDTH  = 3,
    parameter int unsigned WINDOW_HEIGHT = 3,
    parameter int unsigned IMAGE_WIDTH   = 640,
    parameter int unsigned IMAGE_HEIGHT  = 480
) (
    input  logic                     clk,
    input  logic                     rst,
    sliding_window_buffer_if.slave   bus
);
    localparam int unsigned XW   = $clog2(IMAGE_WIDTH);
    localparam int unsigned YW   = $clog2(IMAGE_HEIGHT);
    localparam int unsigned LB_N = WINDOW_HEIGHT - 1;

    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic [XW-1:0] cur_col;
    logic [YW-1:0] cur_row;
    logic          sof;
    logic          at_row_end;
    logic          at_frame_end;
    logic          win_ok;

    logic [WINDOW_HEIGHT-1:0][DATA_BITS-1:0]                    col_vec;
    logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][DATA_BITS-1:0]  win;

    logic          out_valid_q;
    logic          frame_done_q;
    logic [XW-1:0] out_x_q;
    logic [YW-1:0] out_y_q;

    // Effective position of the incoming pixel (resync overrides the counters)
    always_comb begin
        sof = 1'b0;
`ifdef SOF_RESYNC_EN
        sof = bus.in_valid & bus.in_sof;
`endif
        cur_col      = sof ? '0 : col;
        cur_row      = sof ? '0 : row;
        at_row_end   = (cur_col == XW'(IMAGE_WIDTH - 1));
        at_frame_end = at_row_end && (cur_row == YW'(IMAGE_HEIGHT - 1));
        // Columns left of WINDOW_WIDTH-1 would mix in the previous row's tail
        win_ok       = (cur_row >= YW'(WINDOW_HEIGHT - 1)) &&
                       (cur_col >= XW'(WINDOW_WIDTH - 1));
    end

    // Newest pixel forms the bottom of the incoming column
    assign col_vec[WINDOW_HEIGHT-1] = bus.in_data;

    // Line buffer k holds image row (row-1-k); the cascade ages rows downward.
    // Non-blocking writes give read-before-write at the shared address.
    for (genvar gk = 0; gk < LB_N; gk++) begin : gen_lb
        logic [DATA_BITS-1:0] mem [IMAGE_WIDTH];
        logic [DATA_BITS-1:0] rd;

        assign rd                  = mem[cur_col];
        assign col_vec[LB_N-1-gk]  = rd;

        if (gk == 0) begin : gen_head
            always_ff @(posedge clk) begin
                if (bus.in_valid) mem[cur_col] <= bus.in_data;
            end
        end else begin : gen_tail
            always_ff @(posedge clk) begin
                if (bus.in_valid) mem[cur_col] <= gen_lb[gk-1].rd;
            end
        end
    end

    // Window rows: shift left, new column enters at WINDOW_WIDTH-1
    for (genvar gr = 0; gr < WINDOW_HEIGHT; gr++) begin : gen_win
        always_ff @(posedge clk) begin
            if (rst) begin
                win[gr] <= '0;
            end else if (bus.in_valid) begin
                win[gr] <= {col_vec[gr], win[gr][WINDOW_WIDTH-1:1]};
            end
        end
    end

    // Raster counters and registered output qualifiers
    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
        end else begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.in_valid) begin
                out_valid_q  <= win_ok;
                frame_done_q <= at_frame_end;
                if (win_ok) begin
                    out_x_q <= cur_col - XW'(WINDOW_WIDTH / 2);
                    out_y_q <= cur_row - YW'(WINDOW_HEIGHT / 2);
                end
                col <= at_row_end ? '0 : cur_col + XW'(1);
                if (at_row_end) begin
                    row <= at_frame_end ? '0 : cur_row + YW'(1);
                end else begin
                    row <= cur_row;
                end
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_window = win;

endmodule
